// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates from a raw hsync/vsync/video_on stream, measures line and frame
// timing against the configured mode, and reports lock state and timing violations.
module vga_sync_receiver #(
  parameter int unsigned HActive    = 640,
  parameter int unsigned HFp        = 16,
  parameter int unsigned HSync      = 96,
  parameter int unsigned HBp        = 48,
  parameter int unsigned VActive    = 480,
  parameter int unsigned VFp        = 10,
  parameter int unsigned VSync      = 2,
  parameter int unsigned VBp        = 33,
  parameter bit          SyncPol    = 1'b0,
  parameter int unsigned LockFrames = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        video_on_i,
  output logic [9:0]  x_o,
  output logic [9:0]  y_o,
  output logic        de_o,
  output logic        locked_o,
  output logic        frame_start_o,
  output logic        h_err_o,
  output logic        v_err_o,
  output logic        de_err_o,
  output logic [11:0] line_len_o,
  output logic [9:0]  frame_lines_o
);

  localparam int unsigned HTotal = HActive + HFp + HSync + HBp;
  localparam int unsigned VTotal = VActive + VFp + VSync + VBp;

  localparam logic [9:0] XMax    = 10'(HTotal - 1);
  localparam logic [9:0] YMax    = 10'(VTotal - 1);
  localparam logic [9:0] XAct    = 10'(HActive);
  localparam logic [9:0] YAct    = 10'(VActive);
  localparam logic [9:0] HEdgeX  = 10'(HActive + HFp);
  localparam logic [9:0] VEdgeY  = 10'(VActive + VFp);
  localparam logic [7:0] LockCnt = 8'(LockFrames);

  typedef enum logic [1:0] {StSearch, StHLock, StAcquire, StLocked} state_e;

  state_e      state_q, state_d;
  logic        hs_s1_q, vs_s1_q, vid_s1_q;
  logic        hs_s2_q, vs_s2_q;
  logic        h_edge, v_edge;

  logic [9:0]  x_q, x_d, x_inc;
  logic [9:0]  y_q, y_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [11:0] h_meas_q, h_meas_d, line_len_q, line_len_d;
  logic [9:0]  v_meas_q, v_meas_d, frame_lines_q, frame_lines_d;

  logic        h_chk, v_chk, v_at_edge;
  logic        h_err_d, v_err_d, h_err_q, v_err_q;
  logic        is_locked;
  logic        de_d, de_q, locked_q, frame_start_d, frame_start_q, de_err_d, de_err_q;

  // Stage 1 sample plus its previous value; sync regs reset to the idle level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_s1_q  <= ~SyncPol;
      vs_s1_q  <= ~SyncPol;
      vid_s1_q <= 1'b0;
      hs_s2_q  <= ~SyncPol;
      vs_s2_q  <= ~SyncPol;
    end else begin
      hs_s1_q  <= hsync_i;
      vs_s1_q  <= vsync_i;
      vid_s1_q <= video_on_i;
      hs_s2_q  <= hs_s1_q;
      vs_s2_q  <= vs_s1_q;
    end
  end

  assign h_edge = (hs_s1_q == SyncPol) && (hs_s2_q != SyncPol);
  assign v_edge = (vs_s1_q == SyncPol) && (vs_s2_q != SyncPol);

  // Coordinate of the sample currently held in stage 1.
  always_comb begin
    x_inc = (x_q == XMax) ? 10'd0 : x_q + 10'd1;
    x_d   = h_edge ? HEdgeX : x_inc;
    y_d   = y_q;
    if (x_d == 10'd0) begin
      y_d = (y_q == YMax) ? 10'd0 : y_q + 10'd1;
    end
    if (state_q == StHLock && v_edge && x_d == 10'd0) begin
      y_d = VEdgeY;
    end
  end

  // An edge off-position and a missing edge at the expected position are both violations.
  always_comb begin
    h_chk     = (state_q != StSearch);
    v_chk     = (state_q == StAcquire) || (state_q == StLocked);
    v_at_edge = (x_d == 10'd0) && (y_d == VEdgeY);
    h_err_d   = h_chk && (h_edge ? (x_inc != HEdgeX) : (x_inc == HEdgeX));
    v_err_d   = v_chk && (v_edge ? !v_at_edge : v_at_edge);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StSearch;
      good_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    unique case (state_q)
      StSearch: begin
        if (h_edge) state_d = StHLock;
      end
      StHLock: begin
        if (v_edge && x_d == 10'd0) begin
          state_d    = StAcquire;
          good_cnt_d = 8'd0;
        end
      end
      StAcquire: begin
        if (v_err_d) begin
          state_d    = StHLock;
          good_cnt_d = 8'd0;
        end else if (v_edge) begin
          good_cnt_d = good_cnt_q + 8'd1;
          if (good_cnt_d == LockCnt) state_d = StLocked;
        end
      end
      StLocked: begin
        if (v_err_d) begin
          state_d    = StHLock;
          good_cnt_d = 8'd0;
        end
      end
      default: state_d = StSearch;
    endcase
    // Horizontal loss overrides any vertical outcome.
    if (h_err_d) begin
      state_d    = StSearch;
      good_cnt_d = 8'd0;
    end
  end

  always_comb begin
    is_locked     = (state_q == StLocked);
    de_d          = (x_d < XAct) && (y_d < YAct);
    frame_start_d = is_locked && (x_d == 10'd0) && (y_d == 10'd0);
    de_err_d      = is_locked && (vid_s1_q != de_d);
  end

  // Measurement counters restart at 1 on their edge and saturate at full scale.
  always_comb begin
    h_meas_d      = h_meas_q;
    line_len_d    = line_len_q;
    v_meas_d      = v_meas_q;
    frame_lines_d = frame_lines_q;
    if (h_edge) begin
      line_len_d = h_meas_q;
      h_meas_d   = 12'd1;
    end else if (h_meas_q != 12'hfff) begin
      h_meas_d = h_meas_q + 12'd1;
    end
    if (v_edge) begin
      frame_lines_d = v_meas_q;
      v_meas_d      = 10'd1;
    end else if (x_d == 10'd0 && v_meas_q != 10'h3ff) begin
      v_meas_d = v_meas_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      de_q          <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      de_err_q      <= 1'b0;
      h_meas_q      <= 12'd0;
      line_len_q    <= 12'd0;
      v_meas_q      <= 10'd0;
      frame_lines_q <= 10'd0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      locked_q      <= is_locked;
      frame_start_q <= frame_start_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      de_err_q      <= de_err_d;
      h_meas_q      <= h_meas_d;
      line_len_q    <= line_len_d;
      v_meas_q      <= v_meas_d;
      frame_lines_q <= frame_lines_d;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign de_o          = de_q;
  assign locked_o      = locked_q;
  assign frame_start_o = frame_start_q;
  assign h_err_o       = h_err_q;
  assign v_err_o       = v_err_q;
  assign de_err_o      = de_err_q;
  assign line_len_o    = line_len_q;
  assign frame_lines_o = frame_lines_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a scaled-down video mode driven by an in-bench
// timing source with one-shot fault injection.
module tb_vga_sync_receiver;

  localparam int HA = 16, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 2, VS = 2, VB = 4, VT = VA + VF + VS + VB;
  localparam int HEDGE = HA + HF, VEDGE = VA + VF, FRAME = HT * VT;
  localparam int EARLY = 3;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        hsync = 1'b1, vsync = 1'b1, video_on = 1'b0;
  logic [9:0]  x_o, y_o, frame_lines_o;
  logic [11:0] line_len_o;
  logic        de_o, locked_o, frame_start_o, h_err_o, v_err_o, de_err_o;

  int errors = 0, checks = 0;
  int gx = 0, gy = VA - 2, px_prev = 0, py_prev = 0;
  bit sup_arm = 0, sup_line = 0, early_arm = 0, early_line = 0;
  bit vid_arm = 0, vear_arm = 0, vear_frame = 0;
  bit hs_act, vs_act;

  vga_sync_receiver #(
    .HActive(HA), .HFp(HF), .HSync(HS), .HBp(HB),
    .VActive(VA), .VFp(VF), .VSync(VS), .VBp(VB),
    .SyncPol(1'b0), .LockFrames(2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .hsync_i      (hsync),
    .vsync_i      (vsync),
    .video_on_i   (video_on),
    .x_o          (x_o),
    .y_o          (y_o),
    .de_o         (de_o),
    .locked_o     (locked_o),
    .frame_start_o(frame_start_o),
    .h_err_o      (h_err_o),
    .v_err_o      (v_err_o),
    .de_err_o     (de_err_o),
    .line_len_o   (line_len_o),
    .frame_lines_o(frame_lines_o)
  );

  initial begin
    #10;
    forever #20 clk = ~clk;
  end

  // Timing source: advances on negedge so inputs are stable at each posedge.
  always @(negedge clk) begin
    px_prev = gx;
    py_prev = gy;
    if (gx == HT - 1) begin
      gx = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end else begin
      gx = gx + 1;
    end
    if (gx == 0) begin
      sup_line   = sup_arm;
      sup_arm    = 0;
      early_line = early_arm;
      early_arm  = 0;
      if (gy == 0) begin
        vear_frame = vear_arm;
        vear_arm   = 0;
      end
    end
    hs_act = (gx >= HEDGE) && (gx < HEDGE + HS);
    if (sup_line) hs_act = 0;
    if (early_line && gx >= HEDGE - EARLY && gx < HEDGE) hs_act = 1;
    vs_act = vear_frame ? (gy >= VA - 2 && gy < VA) : (gy >= VEDGE && gy < VEDGE + VS);
    hsync    = ~hs_act;
    vsync    = ~vs_act;
    video_on = (gx < HA) && (gy < VA);
    if (vid_arm && gx == 5 && gy == 5) begin
      video_on = 1'b0;
      vid_arm  = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lock(input int limit, output bit got, output int herrs, output int verrs);
    got = 0;
    herrs = 0;
    verrs = 0;
    for (int n = 0; n < limit; n++) begin
      tick();
      if (h_err_o === 1'b1) herrs++;
      if (v_err_o === 1'b1) verrs++;
      if (locked_o === 1'b1) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    #3;
    checks++;
    if (x_o !== 10'd0 || y_o !== 10'd0) begin
      errors++;
      $display("FAIL reset_xy: x=%0d y=%0d required 0 0", x_o, y_o);
    end
    checks++;
    if ({de_o, locked_o, frame_start_o, h_err_o, v_err_o, de_err_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: de/lk/fs/he/ve/dee=%b required 000000",
               {de_o, locked_o, frame_start_o, h_err_o, v_err_o, de_err_o});
    end
    checks++;
    if (line_len_o !== 12'd0 || frame_lines_o !== 10'd0) begin
      errors++;
      $display("FAIL reset_meas: line_len=%0d frame_lines=%0d required 0 0",
               line_len_o, frame_lines_o);
    end
    #95 rst_ni = 1'b1;
  endtask

  task automatic test_acquire();
    bit got = 0;
    bit exp_de;
    int fs = 0;
    for (int n = 0; n < 6 * FRAME; n++) begin
      tick();
      if (locked_o === 1'b1) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL acquire_lock: locked=%b required 1", locked_o);
    end
    for (int n = 0; n < 3 * FRAME; n++) begin
      tick();
      exp_de = (px_prev < HA) && (py_prev < VA);
      checks++;
      if (x_o !== 10'(px_prev) || y_o !== 10'(py_prev)) begin
        errors++;
        $display("FAIL track_xy: x=%0d y=%0d required %0d %0d", x_o, y_o, px_prev, py_prev);
      end
      checks++;
      if (de_o !== exp_de) begin
        errors++;
        $display("FAIL track_de: de=%b required %b", de_o, exp_de);
      end
      checks++;
      if ({h_err_o, v_err_o, de_err_o, locked_o} !== 4'b0001) begin
        errors++;
        $display("FAIL track_flags: he/ve/dee/lk=%b required 0001",
                 {h_err_o, v_err_o, de_err_o, locked_o});
      end
      if (frame_start_o === 1'b1) begin
        fs++;
        checks++;
        if (x_o !== 10'd0 || y_o !== 10'd0) begin
          errors++;
          $display("FAIL frame_start_pos: x=%0d y=%0d required 0 0", x_o, y_o);
        end
      end
    end
    checks++;
    if (fs != 3) begin
      errors++;
      $display("FAIL frame_start_count: got %0d required 3", fs);
    end
    checks++;
    if (line_len_o !== 12'(HT)) begin
      errors++;
      $display("FAIL line_len: got %0d required %0d", line_len_o, HT);
    end
    checks++;
    if (frame_lines_o !== 10'(VT)) begin
      errors++;
      $display("FAIL frame_lines: got %0d required %0d", frame_lines_o, VT);
    end
  endtask

  task automatic test_missing_hsync();
    bit got = 0;
    int herrs, verrs;
    tick();
    sup_arm = 1;
    for (int n = 0; n < 3 * HT; n++) begin
      tick();
      if (h_err_o === 1'b1) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL miss_h_err: h_err=%b required 1", h_err_o);
    end
    checks++;
    if (x_o !== 10'(HEDGE) || y_o !== 10'(py_prev) || locked_o !== 1'b1) begin
      errors++;
      $display("FAIL miss_h_pos: x=%0d y=%0d lk=%b required %0d %0d 1",
               x_o, y_o, locked_o, HEDGE, py_prev);
    end
    tick();
    checks++;
    if (locked_o !== 1'b0 || h_err_o !== 1'b0) begin
      errors++;
      $display("FAIL miss_h_after: lk=%b h_err=%b required 0 0", locked_o, h_err_o);
    end
    wait_lock(6 * FRAME, got, herrs, verrs);
    checks++;
    if (!got || herrs != 0 || verrs != 0) begin
      errors++;
      $display("FAIL miss_h_relock: relocked=%b h_errs=%0d v_errs=%0d required 1 0 0",
               got, herrs, verrs);
    end
  endtask

  task automatic test_early_hsync();
    bit got = 0;
    int herrs = 0, verrs;
    tick();
    early_arm = 1;
    for (int n = 0; n < 3 * HT; n++) begin
      tick();
      if (h_err_o === 1'b1) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got || x_o !== 10'(HEDGE) || line_len_o !== 12'(HT - EARLY) || locked_o !== 1'b1) begin
      errors++;
      $display("FAIL early_h_err: he=%b x=%0d line_len=%0d lk=%b required 1 %0d %0d 1",
               h_err_o, x_o, line_len_o, locked_o, HEDGE, HT - EARLY);
    end
    got = 0;
    for (int n = 0; n < 2 * HT; n++) begin
      tick();
      if (h_err_o === 1'b1) herrs++;
      if (line_len_o !== 12'(HT - EARLY)) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got || line_len_o !== 12'(HT + EARLY) || x_o !== 10'(px_prev) || herrs != 0) begin
      errors++;
      $display("FAIL early_h_next: line_len=%0d x=%0d h_errs=%0d required %0d %0d 0",
               line_len_o, x_o, herrs, HT + EARLY, px_prev);
    end
    wait_lock(6 * FRAME, got, herrs, verrs);
    checks++;
    if (!got || herrs != 0) begin
      errors++;
      $display("FAIL early_h_relock: relocked=%b h_errs=%0d required 1 0", got, herrs);
    end
  endtask

  task automatic test_de_err();
    int pulses = 0, drops = 0;
    tick();
    vid_arm = 1;
    for (int n = 0; n < 2 * FRAME; n++) begin
      tick();
      if (locked_o !== 1'b1) drops++;
      if (de_err_o === 1'b1) begin
        pulses++;
        checks++;
        if (x_o !== 10'd5 || y_o !== 10'd5) begin
          errors++;
          $display("FAIL de_err_pos: x=%0d y=%0d required 5 5", x_o, y_o);
        end
      end
    end
    checks++;
    if (pulses != 1 || drops != 0) begin
      errors++;
      $display("FAIL de_err_count: pulses=%0d unlocked=%0d required 1 0", pulses, drops);
    end
  endtask

  task automatic test_early_vsync();
    bit got = 0;
    int herrs, verrs;
    int exp_fl = 1 + (VT - 1 - VEDGE) + (VA - 2);
    tick();
    vear_arm = 1;
    for (int n = 0; n < 3 * FRAME; n++) begin
      tick();
      if (v_err_o === 1'b1) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got || x_o !== 10'd0 || y_o !== 10'(VA - 2) || h_err_o !== 1'b0 || locked_o !== 1'b1) begin
      errors++;
      $display("FAIL early_v_err: ve=%b x=%0d y=%0d he=%b lk=%b required 1 0 %0d 0 1",
               v_err_o, x_o, y_o, h_err_o, locked_o, VA - 2);
    end
    checks++;
    if (frame_lines_o !== 10'(exp_fl)) begin
      errors++;
      $display("FAIL early_v_lines: frame_lines=%0d required %0d", frame_lines_o, exp_fl);
    end
    tick();
    checks++;
    if (locked_o !== 1'b0) begin
      errors++;
      $display("FAIL early_v_unlock: lk=%b required 0", locked_o);
    end
    wait_lock(6 * FRAME, got, herrs, verrs);
    checks++;
    if (!got || herrs != 0 || verrs != 0) begin
      errors++;
      $display("FAIL early_v_relock: relocked=%b h_errs=%0d v_errs=%0d required 1 0 0",
               got, herrs, verrs);
    end
  endtask

  task automatic test_reset_midline();
    int herrs = 0;
    for (int n = 0; n < HT + 1; n++) begin
      tick();
      if (px_prev == 5) break;
    end
    #5 rst_ni = 1'b0;
    #1;
    checks++;
    if ({x_o, y_o} !== 20'd0 ||
        {de_o, locked_o, frame_start_o, h_err_o, v_err_o, de_err_o} !== 6'b0 ||
        line_len_o !== 12'd0 || frame_lines_o !== 10'd0) begin
      errors++;
      $display("FAIL midline_reset: x=%0d y=%0d flags=%b ll=%0d fl=%0d required all 0",
               x_o, y_o, {de_o, locked_o, frame_start_o, h_err_o, v_err_o, de_err_o},
               line_len_o, frame_lines_o);
    end
    @(negedge clk);
    @(negedge clk);
    #5 rst_ni = 1'b1;
    for (int n = 0; n < 3 * HT; n++) begin
      tick();
      if (h_err_o === 1'b1 || v_err_o === 1'b1) herrs++;
    end
    checks++;
    if (herrs != 0) begin
      errors++;
      $display("FAIL midline_no_err: error pulses=%0d required 0", herrs);
    end
    checks++;
    if (x_o !== 10'(px_prev) || locked_o !== 1'b0) begin
      errors++;
      $display("FAIL midline_hlock: x=%0d lk=%b required %0d 0", x_o, locked_o, px_prev);
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_missing_hsync();
    test_early_hsync();
    test_de_err();
    test_early_vsync();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
